div_nat: RTL and testbench
==========================

# div_nat

Sequential divider for naturals in base 2: 2N-bit dividend x, N-bit divisor y. Produces quotient q and remainder r on N bits each, with x = q·y + r and r < y. It is the inverse of the multiply-add unit m = x·y + c. It uses restoring shift-subtract, one quotient bit per clock, and talks to its consumer over the soc/eoc handshake. A fast overflow check rejects any division whose quotient would not fit in N bits, including y = 0.

## Interface
Parameters:
- N, default 8: width of divisor, quotient and remainder. The dividend is 2N bits.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset_  in  1  asynchronous, active-low reset.
- soc  in  1  start of conversion, driven by the consumer.
- x  in  2N  dividend, natural. Sampled only at start.
- y  in  N  divisor, natural. Sampled only at start.
- eoc  out  1  end of conversion. 1 = idle and results valid; 0 = busy.
- q  out  N  quotient. Registered; changes only when eoc rises.
- r  out  N  remainder. Registered; changes only when eoc rises.
- ovf  out  1  1 = quotient not representable on N bits (x[2N-1:N] ≥ y, including y = 0). Registered with q and r.

## Operation
- Internal registers:
  - STAR: state.
  - R: partial remainder, N bits.
  - Q: shifted dividend low half / quotient, N bits.
  - Y: divisor, N bits.
  - COUNT: ⌈log2(N+1)⌉ bits.
- Reset (reset_ = 0, effective immediately, not clocked): STAR = IDLE, eoc = 1, q = 0, r = 0, ovf = 0. Any operation in progress is aborted with no partial results.
- IDLE (eoc = 1):
  - If soc = 1: R ← x[2N-1:N], Q ← x[N-1:0], Y ← y, COUNT ← N, eoc ← 0, go to CHECK.
  - Otherwise hold.
- CHECK:
  - If R ≥ Y (unsigned N-bit compare): go to DONE with overflow pending.
  - Otherwise go to STEP with overflow cleared.
- STEP, one iteration per clock:
  - T = {R, Q[N-1]} is N+1 bits. D = T − {0, Y} uses an (N+1)-bit subtractor; its borrow out b selects the result.
  - If b = 0: R ← D[N-1:0], Q ← {Q[N-2:0], 1}.
  - If b = 1: R ← T[N-1:0], Q ← {Q[N-2:0], 0}.
  - COUNT ← COUNT − 1. If COUNT = 1 before the decrement, go to DONE.
- DONE:
  - While soc = 1, hold; eoc stays 0 and outputs are unchanged.
  - When soc = 0:
    - No overflow: q ← Q, r ← R, ovf ← 0.
    - Overflow: q ← 0, r ← 0, ovf ← 1.
    - In both cases eoc ← 1, go to IDLE.
- Width rules:
  - Because R < Y holds throughout STEP, T < 2^(N+1) and D[N] = 0 whenever b = 0.
  - The final R < Y ≤ 2^N − 1, so r always fits in N bits.
- Changes on x and y after the sampling edge have no effect. soc pulses while busy are absorbed by the protocol and never start a second operation.

## Timing
- Handshake sequence:
  1. Consumer raises soc while eoc = 1.
  2. Block drops eoc at the next edge.
  3. Consumer lowers soc after seeing eoc = 0.
  4. Block raises eoc with valid q, r, ovf.
  5. Consumer reads, and may raise soc again in the same cycle eoc = 1 is seen.
- Normal latency (soc already 0 by DONE), counted from the edge sampling soc = 1 (edge 1):
  - Edge 1 → CHECK.
  - Edge 2 → STEP.
  - Edges 3..N+2 → the N steps.
  - Edge N+3 → eoc = 1.
  - For N = 8, eoc rises 11 clocks after the start edge.
- Overflow latency: eoc rises at edge 3.
- Held soc: if soc is still 1 in DONE, eoc rises at the first edge where soc = 0 is sampled.
- Between eoc falling and rising, q, r and ovf keep the previous result.

## Test plan
- Reset: drive reset_ = 0 mid-clock, with no clock edge → eoc = 1, q = 0, r = 0, ovf = 0 immediately.
- Normal: N = 8, x = 1000 (0x03E8), y = 7, soc dropped after eoc falls → q = 142, r = 6, ovf = 0; eoc rises exactly 11 clocks after the start edge.
- Boundary: x = 65279, y = 255 → q = 255, r = 254, ovf = 0. Also x = 0, y = 1 → q = 0, r = 0.
- Overflow:
  - y = 0, x = 5 → ovf = 1, q = 0, r = 0, eoc after 3 clocks.
  - x = 0x0700, y = 7 → ovf = 1.
  - x = 0x06FF, y = 7 → q = 255, r = 6.
- Protocol:
  - Hold soc = 1 for 20 clocks and change x and y after the start edge → eoc stays 0 until soc falls, then rises on the next edge with the result of the originally sampled operands.
  - Back-to-back operations: raise soc in the same cycle eoc is seen at 1 → second result correct.
- Abort and random check:
  - Assert reset_ during the 4th STEP → outputs return to reset values at once; a following operation x = 200, y = 9 gives q = 22, r = 2.
  - Run 1000 random cases with y ≠ 0 and x[15:8] < y → q·y + r = x and r < y.

Source files
------------

// File: rtl/div_nat.sv
// ============================================================================
// div_nat -- restoring shift-subtract divider, 2N-bit / N-bit naturals
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_nat #(
  parameter int N = 8
) (
  input  logic           clock,
  input  logic           reset_,
  input  logic           soc,
  input  logic [2*N-1:0] x,
  input  logic [N-1:0]   y,
  output logic           eoc,
  output logic [N-1:0]   q,
  output logic [N-1:0]   r,
  output logic           ovf
);

  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_STEP  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [N-1:0]  r_rem;
  logic [N-1:0]  r_quo;
  logic [N-1:0]  r_div;
  logic [CW-1:0] r_cnt;
  logic          r_ovf_p;

  logic [N:0]    w_t;
  logic [N-1:0]  w_d;
  logic          w_borrow;
  logic          w_ge;

  // When no borrow occurs the true difference is below 2^N, so an N-bit
  // subtract gives the exact result and the borrow comes from the compare.
  assign w_t      = {r_rem, r_quo[N-1]};
  assign w_borrow = (w_t < {1'b0, r_div});
  assign w_d      = w_t[N-1:0] - r_div;
  assign w_ge     = (r_rem >= r_div);

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (soc) w_next = S_CHECK;
      S_CHECK: w_next = w_ge ? S_DONE : S_STEP;
      S_STEP:  if (r_cnt == CW'(1)) w_next = S_DONE;
      S_DONE:  if (!soc) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    eoc = (r_state == S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_cnt   <= '0;
      r_ovf_p <= 1'b0;
      q       <= '0;
      r       <= '0;
      ovf     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (soc) begin
            r_rem <= x[2*N-1:N];
            r_quo <= x[N-1:0];
            r_div <= y;
            r_cnt <= CW'(N);
          end
        end
        S_CHECK: begin
          r_ovf_p <= w_ge;
        end
        S_STEP: begin
          r_rem <= w_borrow ? w_t[N-1:0] : w_d;
          r_quo <= {r_quo[N-2:0], ~w_borrow};
          r_cnt <= r_cnt - CW'(1);
        end
        S_DONE: begin
          // Results are published only once the consumer has released soc.
          if (!soc) begin
            q   <= r_ovf_p ? '0 : r_quo;
            r   <= r_ovf_p ? '0 : r_rem;
            ovf <= r_ovf_p;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div_nat.sv
// ============================================================================
// tb_div_nat -- self-checking bench for div_nat (N = 8)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_div_nat;

  localparam int N = 8;

  logic        clock  = 1'b0;
  logic        reset_ = 1'b0;
  logic        soc    = 1'b0;
  logic [15:0] x      = '0;
  logic [7:0]  y      = '0;
  logic        eoc;
  logic [7:0]  q;
  logic [7:0]  r;
  logic        ovf;

  div_nat #(.N(N)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .soc    (soc),
    .x      (x),
    .y      (y),
    .eoc    (eoc),
    .q      (q),
    .r      (r),
    .ovf    (ovf)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       ovf;
  } res_t;

  res_t pend[$];
  res_t cur;
  int   errors   = 0;
  int   checks   = 0;
  logic chk_en   = 1'b0;
  logic prev_eoc = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division with the overflow rule.
  function automatic res_t model(input logic [15:0] xx, input logic [7:0] yy);
    res_t m;
    if (yy == 8'd0 || xx[15:8] >= yy) begin
      m.q = 8'd0; m.r = 8'd0; m.ovf = 1'b1;
    end else begin
      m.q = 8'(xx / 16'(yy)); m.r = 8'(xx % 16'(yy)); m.ovf = 1'b0;
    end
    return m;
  endfunction

  // Visible results must always equal the last completed operation.
  always @(negedge clock) begin
    if (chk_en) begin
      if (eoc && !prev_eoc && pend.size() > 0) cur = pend.pop_front();
      prev_eoc = eoc;
      chk("cmp_q",   32'(q),   32'(cur.q));
      chk("cmp_r",   32'(r),   32'(cur.r));
      chk("cmp_ovf", 32'(ovf), 32'(cur.ovf));
    end
  end

  task automatic do_op(input logic [15:0] xx, input logic [7:0] yy, input int hold,
                       input bit chk_lat, input int exp_lat, input bit chk_val,
                       input logic [7:0] eq, input logic [7:0] er, input logic eo);
    int   cyc;
    logic rose;
    res_t m;
    m = model(xx, yy);
    pend.push_back(m);
    x = xx; y = yy; soc = 1'b1;
    @(posedge clock); #1; cyc = 1;
    chk("eoc_fall", 32'(eoc), 32'd0);
    rose = 1'b0;
    for (int i = 1; i < hold; i++) begin
      x = 16'($urandom); y = 8'($urandom);
      @(posedge clock); #1; cyc++;
      if (eoc) rose = 1'b1;
    end
    if (hold > 1) chk("eoc_held", 32'(rose), 32'd0);
    soc = 1'b0;
    while (!eoc && cyc < 200) begin
      @(posedge clock); #1; cyc++;
    end
    chk("eoc_rise", 32'(eoc), 32'd1);
    if (chk_lat) chk("latency", 32'(cyc), 32'(exp_lat));
    if (chk_val) begin
      chk("q", 32'(q), 32'(eq));
      chk("r", 32'(r), 32'(er));
      chk("ovf", 32'(ovf), 32'(eo));
    end else if (!m.ovf) begin
      chk("qy_plus_r", 32'(q) * 32'(yy) + 32'(r), 32'(xx));
      chk("r_lt_y", 32'(r < yy), 32'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_eoc"}, 32'(eoc), 32'd1);
    chk({tag, "_q"},   32'(q),   32'd0);
    chk({tag, "_r"},   32'(r),   32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  initial begin
    logic [7:0]  ry;
    logic [15:0] rx;

    @(posedge clock); #1;
    check_reset_outputs("rst_init");
    #2 reset_ = 1'b1;
    cur = '0; prev_eoc = 1'b1; chk_en = 1'b1;
    @(posedge clock); #1;

    do_op(16'd1000, 8'd7, 1, 1, 11, 1, 8'd142, 8'd6, 1'b0);

    // Asynchronous reset between edges, no clock edge in between.
    #2 reset_ = 1'b0;
    #1 check_reset_outputs("rst_async");
    pend.delete(); cur = '0;
    #2 reset_ = 1'b1;
    @(posedge clock); #1;

    do_op(16'd65279, 8'd255, 1, 1, 11, 1, 8'd255, 8'd254, 1'b0);
    do_op(16'd0,     8'd1,   1, 1, 11, 1, 8'd0,   8'd0,   1'b0);
    do_op(16'd5,     8'd0,   1, 1, 3,  1, 8'd0,   8'd0,   1'b1);
    do_op(16'h0700,  8'd7,   1, 1, 3,  1, 8'd0,   8'd0,   1'b1);
    do_op(16'h06FF,  8'd7,   1, 1, 11, 1, 8'd255, 8'd6,   1'b0);

    do_op(16'd1234, 8'd10, 20, 1, 21, 1, 8'd123, 8'd4, 1'b0);

    do_op(16'd500, 8'd3, 1, 1, 11, 1, 8'd166, 8'd2, 1'b0);
    do_op(16'd300, 8'd4, 1, 1, 11, 1, 8'd75,  8'd0, 1'b0);

    // Abort in the middle of the fourth step.
    x = 16'd5000; y = 8'd50; soc = 1'b1;
    @(posedge clock); #1; soc = 1'b0;
    repeat (4) @(posedge clock);
    #3 reset_ = 1'b0;
    #1 check_reset_outputs("rst_abort");
    cur = '0;
    #3 reset_ = 1'b1;
    @(posedge clock); #1;
    do_op(16'd200, 8'd9, 1, 1, 11, 1, 8'd22, 8'd2, 1'b0);

    for (int k = 0; k < 1000; k++) begin
      ry = 8'($urandom_range(1, 255));
      rx = {8'($urandom_range(0, int'(ry) - 1)), 8'($urandom)};
      do_op(rx, ry, 1, 1, 11, 0, 8'd0, 8'd0, 1'b0);
    end

    @(negedge clock); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
